// File: rtl/uart_mmio_fifo_if.sv
// CPU load/store bus between the pipeline and the UART MMIO block.
interface uart_mmio_fifo_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic        stall;
  logic        hit;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, rd_en, wr_en, stall,
    input  hit, rdata
  );

  modport slave (
    input  addr, wdata, rd_en, wr_en, stall,
    output hit, rdata
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, status/control/flag
// registers and a registered level interrupt.
module uart_mmio_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_mmio_fifo_if.slave  bus,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             irq
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OFF_TX_STAT = 3'd0;
  localparam logic [2:0] OFF_RX_STAT = 3'd1;
  localparam logic [2:0] OFF_TX_DATA = 3'd2;
  localparam logic [2:0] OFF_RX_DATA = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_COUNTS  = 3'd5;
  localparam logic [2:0] OFF_FLAGS   = 3'd6;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_ovf, rx_ie, tx_ie;

  logic          region, commit, wr_commit, rd_commit;
  logic [2:0]    off;
  logic          tx_push, tx_pop, tx_ovf_set;
  logic          rx_push, rx_pop, rx_ovf_set;
  logic          flag_wr;
  logic [31:0]   rdata_c;
  logic          unused_bits;

  assign unused_bits = ^{bus.addr[27:5], bus.addr[1:0], bus.wdata[31:8]};

  // Address decode; a write wins over a read in the same cycle
  assign region    = (bus.addr[31:28] == 4'b1000);
  assign off       = bus.addr[4:2];
  assign bus.hit   = region && (bus.rd_en || bus.wr_en);
  assign commit    = bus.hit && !bus.stall;
  assign wr_commit = commit && bus.wr_en;
  assign rd_commit = commit && bus.rd_en && !bus.wr_en;

  // Fullness/emptiness judged on pre-edge counts
  assign tx_valid   = (tx_cnt != '0);
  assign tx_data    = tx_mem[tx_rd];
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_push    = wr_commit && (off == OFF_TX_DATA) && (tx_cnt != FULL);
  assign tx_ovf_set = wr_commit && (off == OFF_TX_DATA) && (tx_cnt == FULL);

  assign rx_ready   = (rx_cnt != FULL);
  assign rx_push    = rx_valid && rx_ready;
  assign rx_ovf_set = rx_valid && (rx_cnt == FULL);
  assign rx_pop     = rd_commit && (off == OFF_RX_DATA) && (rx_cnt != '0);

  assign flag_wr    = wr_commit && (off == OFF_FLAGS);

  always_comb begin
    rdata_c = '0;
    if (bus.hit) begin
      case (off)
        OFF_TX_STAT: rdata_c = {31'b0, (tx_cnt != FULL)};
        OFF_RX_STAT: rdata_c = {31'b0, (rx_cnt != '0)};
        OFF_RX_DATA: if (rx_cnt != '0) rdata_c = {24'b0, rx_mem[rx_rd]};
        OFF_CTRL:    rdata_c = {30'b0, tx_ie, rx_ie};
        OFF_COUNTS:  rdata_c = 32'(tx_cnt) | (32'(rx_cnt) << 16);
        OFF_FLAGS:   rdata_c = {30'b0, rx_ovf, tx_ovf};
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;

  // Storage is never reset; pointers and counts define what is valid
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.wdata[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Control, sticky flags (set beats clear) and registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_commit && (off == OFF_CTRL)) begin
        rx_ie <= bus.wdata[0];
        tx_ie <= bus.wdata[1];
      end
      tx_ovf <= tx_ovf_set || (tx_ovf && !(flag_wr && bus.wdata[0]));
      rx_ovf <= rx_ovf_set || (rx_ovf && !(flag_wr && bus.wdata[1]));
      irq    <= (rx_ie && (rx_cnt != '0)) || (tx_ie && (tx_cnt == '0))
                || tx_ovf || rx_ovf;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: FIFO ordering, overflow, stall,
// interrupt timing and reset, with hand-computed expectations.
module tb_uart_mmio_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  uart_mmio_fifo_if bus ();

  uart_mmio_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.stall = 1'b0;
  endtask

  function automatic logic [31:0] uaddr(input int unsigned off);
    return 32'h8000_0000 | 32'(off << 2);
  endfunction

  task automatic bus_wr(input int unsigned off, input logic [31:0] d);
    bus.addr  = uaddr(off);
    bus.wdata = d;
    bus.wr_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd_chk(input string tag, input int unsigned off, input logic [31:0] exp);
    bus.addr  = uaddr(off);
    bus.rd_en = 1'b1;
    #1;
    check(tag, bus.rdata, exp);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst      = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and decode
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    bus.addr = uaddr(0);
    #1;
    check("no_en_hit", 32'(bus.hit), 32'd0);
    check("no_en_rdata", bus.rdata, 32'd0);
    bus.addr  = 32'h4000_0014;
    bus.rd_en = 1'b1;
    #1;
    check("out_region_hit", 32'(bus.hit), 32'd0);
    check("out_region_rdata", bus.rdata, 32'd0);
    bus.addr = uaddr(0);
    #1;
    check("in_region_hit", 32'(bus.hit), 32'd1);
    idle();
    rd_chk("rst_tx_stat", 0, 32'd1);
    rd_chk("rst_counts", 5, 32'd0);
    rd_chk("rst_ctrl", 4, 32'd0);
    rd_chk("rsvd_rd", 7, 32'd0);

    // TX ordering
    bus_wr(2, 32'hFFFF_FF41);
    bus_wr(2, 32'h0000_0042);
    bus_wr(2, 32'h0000_0043);
    rd_chk("tx3_counts", 5, 32'd3);
    check("tx3_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    #1;
    check("tx_head0", 32'(tx_data), 32'h41);
    tick();
    check("tx_head1", 32'(tx_data), 32'h42);
    tick();
    check("tx_head2", 32'(tx_data), 32'h43);
    tick();
    check("tx_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i < 9; i++) bus_wr(2, 32'h60 + 32'(i));
    rd_chk("tx_full_counts", 5, 32'd8);
    rd_chk("tx_ovf_flags", 6, 32'd1);
    rd_chk("tx_full_stat", 0, 32'd0);
    check("tx_ovf_irq", 32'(irq), 32'd1);
    bus_wr(6, 32'd1);
    rd_chk("tx_ovf_clr", 6, 32'd0);
    tx_ready = 1'b1;
    bus_wr(2, 32'h99);
    tx_ready = 1'b0;
    rd_chk("full_pop_counts", 5, 32'd7);
    rd_chk("full_pop_flags", 6, 32'd1);
    check("full_pop_head", 32'(tx_data), 32'h61);
    bus_wr(6, 32'd1);
    tx_ready = 1'b1;
    repeat (7) tick();
    tx_ready = 1'b0;
    check("tx_empty_again", 32'(tx_valid), 32'd0);
    check("irq_after_clear", 32'(irq), 32'd0);

    // RX fill, overflow, stall and drain
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      tick();
    end
    check("rx_full_ready", 32'(rx_ready), 32'd0);
    rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    rd_chk("rx_ovf_flags", 6, 32'd2);
    rd_chk("rx_full_counts", 5, 32'h0008_0000);
    rd_chk("rx_full_stat", 1, 32'd1);
    bus.addr  = uaddr(3);
    bus.rd_en = 1'b1;
    bus.stall = 1'b1;
    #1;
    check("rx_stall_rd", bus.rdata, 32'h10);
    tick();
    bus.stall = 1'b0;
    #1;
    check("rx_after_stall", bus.rdata, 32'h10);
    tick();
    idle();
    for (int i = 1; i < 8; i++) rd_chk("rx_pop", 3, 32'h10 + 32'(i));
    rd_chk("rx_empty_stat", 1, 32'd0);
    rd_chk("rx_empty_rd", 3, 32'd0);
    bus_wr(6, 32'd3);
    rd_chk("flags_cleared", 6, 32'd0);

    // Interrupt timing
    bus_wr(4, 32'd1);
    rd_chk("ctrl_rx_ie", 4, 32'd1);
    check("irq_idle", 32'(irq), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    rx_valid = 1'b0;
    check("irq_push_same", 32'(irq), 32'd0);
    tick();
    check("irq_push_next", 32'(irq), 32'd1);
    bus.addr  = uaddr(3);
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b1;
    tick();
    idle();
    rd_chk("rdwr_no_pop", 5, 32'h0001_0000);
    rd_chk("rx_pop_irq", 3, 32'hA5);
    check("irq_pop_same", 32'(irq), 32'd1);
    tick();
    check("irq_pop_next", 32'(irq), 32'd0);
    bus_wr(4, 32'd2);
    tick();
    check("irq_tx_ie", 32'(irq), 32'd1);
    bus_wr(4, 32'd0);
    tick();
    check("irq_ie_off", 32'(irq), 32'd0);

    // Empty read racing a push, then reset mid-transfer
    rx_valid  = 1'b1;
    rx_data   = 8'h77;
    bus.addr  = uaddr(3);
    bus.rd_en = 1'b1;
    #1;
    check("empty_rd_push", bus.rdata, 32'd0);
    tick();
    rx_valid = 1'b0;
    idle();
    rd_chk("empty_rd_counts", 5, 32'h0001_0000);
    for (int i = 0; i < 5; i++) bus_wr(2, 32'hA0 + 32'(i));
    rd_chk("pre_rst_counts", 5, 32'h0001_0005);
    tx_ready = 1'b1;
    rst      = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
    tx_ready = 1'b1;
    tick();
    rst      = 1'b0;
    tx_ready = 1'b0;
    rd_chk("post_rst_counts", 5, 32'd0);
    rd_chk("post_rst_rx_stat", 1, 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_fifo.md
UART_MMIO_FIFO -- requirements
Module: uart_mmio_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the entries per FIFO; it is a power of two, 2..256.
REQ-002 The block SHALL have parameter AW = log2(DEPTH), default 3, meaning the FIFO index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr  in  32  CPU data address; UART region when addr[31:28]==4'b1000.
REQ-006 wdata  in  32  CPU store data; only [7:0] used for TX data.
REQ-007 rd_en  in  1  CPU load in progress this cycle.
REQ-008 wr_en  in  1  CPU store in progress this cycle.
REQ-009 stall  in  1  pipeline stall; when high, no access commits (no push, pop, register write or flag clear).
REQ-010 hit  out  1  high when the UART region is decoded and rd_en or wr_en is set; combinational.
REQ-011 rdata  out  32  load data; combinational from addr and state.
REQ-012 tx_data  out  8  byte to UART transmitter (TX FIFO head).
REQ-013 tx_valid  out  1  TX FIFO non-empty.
REQ-014 tx_ready  in  1  transmitter accepts tx_data.
REQ-015 rx_data  in  8  byte from UART receiver.
REQ-016 rx_valid  in  1  rx_data valid.
REQ-017 rx_ready  out  1  RX FIFO not full.
REQ-018 irq  out  1  level interrupt request.

Function
REQ-019 The register map SHALL decode on addr[4:2] in the UART region:
- 0: TX status (R), bit0 = TX not full.
- 1: RX status (R), bit0 = RX not empty.
- 2: TX data (W).
- 3: RX data (R, pop).
- 4: control (R/W), bit0 rx_ie, bit1 tx_ie.
- 5: counts (R), [8:0] TX count, [24:16] RX count.
- 6: flags (R/W1C), bit0 tx_ovf, bit1 rx_ovf.
- 7: reserved; reads 0, writes ignored.
REQ-020 A committed access SHALL be rd_en or wr_en high, stall low, and the region decoded; only committed accesses change state.
REQ-021 A committed write to offset 2 SHALL push wdata[7:0] into the TX FIFO when TX count < DEPTH.
REQ-022 A TX write when TX count == DEPTH SHALL drop the byte and set tx_ovf; fullness is judged on the pre-edge count, even if a pop occurs in the same cycle.
REQ-023 tx_valid SHALL equal (TX count != 0), tx_data SHALL equal the head entry, and a pop SHALL occur on tx_valid && tx_ready.
REQ-024 rx_ready SHALL equal (RX count != DEPTH), and a push of rx_data SHALL occur on rx_valid && rx_ready.
REQ-025 rx_ovf SHALL be set when rx_valid is high while RX count == DEPTH; that byte is lost.
REQ-026 A committed read of offset 3 SHALL return {24'b0, head} and pop when RX count != 0.
REQ-027 A read of offset 3 when RX is empty SHALL return 0 with no pop, even if a push lands in the same cycle.
REQ-028 Simultaneous push and pop on either FIFO SHALL leave the count unchanged and advance both pointers.
REQ-029 Each FIFO SHALL use read/write pointers of AW bits that wrap modulo DEPTH, plus a count of AW+1 bits in 0..DEPTH.
REQ-030 A committed write to offset 6 SHALL clear each flag whose wdata bit is 1.
REQ-031 A flag clear and a flag set in the same cycle SHALL leave the flag set.
REQ-032 A committed write to offset 4 SHALL load wdata[1:0] into rx_ie and tx_ie.
REQ-033 irq SHALL equal (rx_ie && RX count != 0) || (tx_ie && TX count == 0) || tx_ovf || rx_ovf; it is registered, so it changes one cycle after its cause.
REQ-034 rdata SHALL be 0 whenever hit is low; when hit is high, unused bits SHALL read 0.
REQ-035 Load latency SHALL be zero cycles for rdata, and pointer, count and flag updates SHALL be visible the next cycle.
REQ-036 A read and a write of different offsets cannot occur together; if rd_en and wr_en are both high, the write SHALL take priority and the read side effect (pop) SHALL be suppressed.

Reset
REQ-037 On rst high at a clock edge, all pointers, counts, tx_ovf, rx_ovf, rx_ie, tx_ie and irq SHALL become 0, giving tx_valid=0 and rx_ready=1.
REQ-038 Reset SHALL override every simultaneous push, pop and write, and FIFO contents need not be cleared.
REQ-039 A reset mid-transfer SHALL discard all queued bytes.

Verification
REQ-040 Writing 0x41,0x42,0x43 to offset 2 with tx_ready=0, then holding tx_ready=1, SHALL show tx_data 0x41,0x42,0x43 on consecutive cycles, after which tx_valid falls.
REQ-041 DEPTH=8: nine TX writes with tx_ready=0 SHALL leave the counts register at TX=8 and the flags register reading 0x1; writing 1 to offset 6 SHALL clear the flag.
REQ-042 Pushing 8 RX bytes 0x10..0x17 SHALL drop rx_ready; a ninth rx_valid SHALL set rx_ovf; eight offset-3 reads SHALL return 0x10..0x17, after which RX status reads 0.
REQ-043 An RX read with stall=1 SHALL return the head byte on rdata with no pop, and the same read with stall=0 next cycle SHALL pop it.
REQ-044 With rx_ie=1 and RX empty, pushing a byte SHALL raise irq one cycle later, and the read that empties RX SHALL lower irq one cycle after the pop.
REQ-045 Asserting rst with 5 TX bytes queued and tx_ready toggling SHALL give tx_valid=0 and counts=0 on the next cycle.
